// File: rtl/ad9634_init_sequencer.sv
// AD9634 bring-up: walks a fixed register table through an SPI frame engine.
// Define AD9634_SEQ_TIMEOUT_EN to add ack/transfer timeouts that end in ERR.
module ad9634_init_sequencer #(
  parameter int GAP_CYCLES   = 8,
  parameter int ACK_TIMEOUT  = 16,
  parameter int XFER_TIMEOUT = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        spi_busy,
  output logic [23:0] cmd_data,
  output logic        cmd_load,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  step
);

  localparam int GW = $clog2(4 * GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state;
  logic [GW-1:0] gap_cnt;
  logic          ack_early;

`ifdef AD9634_SEQ_TIMEOUT_EN
  localparam int TMAX = (ACK_TIMEOUT > XFER_TIMEOUT) ?
                        ACK_TIMEOUT : XFER_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Write frame: rw=0, one byte, 13-bit address, data byte.
  function automatic logic [23:0] frame(input logic [2:0] idx);
    logic [12:0] a;
    logic [7:0]  d;
    case (idx)
      3'd0:    begin a = 13'h000; d = 8'h3C; end
      3'd1:    begin a = 13'h008; d = 8'h00; end
      3'd2:    begin a = 13'h014; d = 8'h00; end
      3'd3:    begin a = 13'h016; d = 8'h00; end
      3'd4:    begin a = 13'h0FF; d = 8'h01; end
      default: begin a = 13'h000; d = 8'h00; end
    endcase
    return {1'b0, 2'b00, a, d};
  endfunction

  // Sequencer FSM; every output is a flop updated with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      step      <= 3'd0;
      cmd_data  <= 24'd0;
      cmd_load  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      gap_cnt   <= '0;
      ack_early <= 1'b0;
`ifdef AD9634_SEQ_TIMEOUT_EN
      tmo_cnt   <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      cmd_load <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state    <= S_LOAD;
            step     <= 3'd0;
            cmd_data <= frame(3'd0);
            cmd_load <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
`ifdef AD9634_SEQ_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          state     <= S_WAIT_ACK;
          ack_early <= spi_busy;
`ifdef AD9634_SEQ_TIMEOUT_EN
          tmo_cnt   <= '0;
`endif
        end
        S_WAIT_ACK: begin
          if (spi_busy || ack_early) begin
            state     <= S_WAIT_DONE;
            ack_early <= 1'b0;
`ifdef AD9634_SEQ_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
          end
`ifdef AD9634_SEQ_TIMEOUT_EN
          else if (tmo_cnt == TW'(ACK_TIMEOUT - 1)) begin
            state <= S_ERR;
            busy  <= 1'b0;
            err_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        S_WAIT_DONE: begin
          if (!spi_busy) begin
            state   <= S_GAP;
            // soft reset needs a longer settle time
            gap_cnt <= (step == 3'd0) ?
                       GW'(4 * GAP_CYCLES - 1) :
                       GW'(GAP_CYCLES - 1);
          end
`ifdef AD9634_SEQ_TIMEOUT_EN
          else if (tmo_cnt == TW'(XFER_TIMEOUT - 1)) begin
            state <= S_ERR;
            busy  <= 1'b0;
            err_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        S_GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else if (step == 3'd4) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state    <= S_LOAD;
            step     <= step + 3'd1;
            cmd_data <= frame(step + 3'd1);
            cmd_load <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ad9634_init_sequencer.md
AD9634_INIT_SEQUENCER -- requirements
Module: ad9634_init_sequencer

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 8: idle cycles between the end of one frame and the next cmd_load.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16: max cycles from cmd_load to spi_busy rising.
REQ-003 SHALL have parameter XFER_TIMEOUT, default 512: max cycles spi_busy may stay high per frame.
REQ-004 SHALL have port clk  in  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1: reset, synchronous and active-high.
REQ-006 SHALL have port start  in  1: begin the sequence; sampled in IDLE, DONE and ERR only.
REQ-007 SHALL have port spi_busy  in  1: high while the downstream SPI controller is shifting a frame.
REQ-008 SHALL have port cmd_data  out  24: frame to the SPI controller data input.
REQ-009 SHALL have port cmd_load  out  1: one-cycle load strobe to the SPI controller.
REQ-010 SHALL have port busy  out  1: high in every state except IDLE, DONE and ERR.
REQ-011 SHALL have port done  out  1: high while in DONE.
REQ-012 SHALL have port err  out  1: high while in ERR.
REQ-013 SHALL have port step  out  3: index of the current or last issued table entry.

Function
REQ-014 SHALL build the frame as cmd_data[23]=0 (write), [22:21]=00 (one byte), [20:8]=13-bit address, [7:0]=data.
REQ-015 SHALL hold a fixed 5-entry table, in order: 0x000/0x3C, 0x008/0x00, 0x014/0x00, 0x016/0x00, 0x0FF/0x01.
REQ-016 SHALL implement states IDLE, LOAD, WAIT_ACK, WAIT_DONE, GAP, DONE, ERR.
REQ-017 IDLE/DONE/ERR with start=1 SHALL go to LOAD with step=0 on the next cycle.
REQ-018 LOAD SHALL drive cmd_data from table[step], assert cmd_load for exactly that cycle, then go to WAIT_ACK.
REQ-019 cmd_data SHALL stay stable from LOAD until the state leaves WAIT_DONE.
REQ-020 WAIT_ACK SHALL go to WAIT_DONE the cycle after spi_busy=1 is seen.
REQ-021 WAIT_DONE SHALL go to GAP when spi_busy=0 is seen.
REQ-022 GAP SHALL count GAP_CYCLES cycles. It SHALL then go to LOAD with step+1, or to DONE if step=4.
REQ-023 spi_busy already high in LOAD SHALL still count as an ack in the first WAIT_ACK cycle.
REQ-024 start asserted while busy=1 SHALL be ignored and SHALL NOT restart the sequence.
REQ-025 cmd_load SHALL never assert outside LOAD, and SHALL assert at most once per table entry.
REQ-026 Entry 0 (soft reset) SHALL use 4*GAP_CYCLES in GAP instead of GAP_CYCLES.
REQ-027 DONE and ERR SHALL hold step at its last value.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, step=0, cmd_data=0, cmd_load=0, busy=0, done=0, err=0, and clear all counters.
REQ-029 rst SHALL override start and any state, including mid-frame. No further cmd_load SHALL occur until a new start.

Configuration
REQ-030 With macro AD9634_SEQ_TIMEOUT_EN defined, WAIT_ACK exceeding ACK_TIMEOUT cycles SHALL go to ERR.
REQ-031 With macro AD9634_SEQ_TIMEOUT_EN defined, WAIT_DONE exceeding XFER_TIMEOUT cycles SHALL go to ERR.
REQ-032 Without AD9634_SEQ_TIMEOUT_EN, WAIT_ACK and WAIT_DONE SHALL wait indefinitely, err SHALL be constant 0, and no timeout counters SHALL be synthesized.

Verification
REQ-033 Nominal run: rst, then start pulse, with a model asserting spi_busy 2 cycles after cmd_load for 100 cycles -> 5 cmd_load pulses with cmd_data 0x00003C, 0x000800, 0x001400, 0x001600, 0x00FF01, then done=1 and step=4.
REQ-034 Gap check, same run with GAP_CYCLES=8 -> 32 cycles between spi_busy falling and the second cmd_load, and 8 cycles before each later cmd_load.
REQ-035 Ack timeout with macro defined: spi_busy held 0 -> err=1 exactly ACK_TIMEOUT cycles after the first WAIT_ACK cycle, step=0, no second cmd_load. Without the macro, the same stimulus leaves busy=1 forever.
REQ-036 Start re-entry: start pulse at step 2 mid-frame -> ignored, sequence completes normally. Start pulse in DONE -> sequence reruns from 0x00003C.
REQ-037 Reset mid-frame: rst asserted during WAIT_DONE of step 3 -> next cycle all outputs are 0 and the state is IDLE. After release, no cmd_load occurs for 50 cycles without a start.
